int_ctrl: RTL and testbench
===========================

INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset (polarity and synchronicity are fixed).
REQ-002 Parameter VEC_HIGH, 32'h0000_0040, service address for the external high-priority interrupt.
REQ-003 Parameter VEC_LOW_BASE, 32'h0000_0080, base address of the low-priority vectors, with a 0x10 stride per source.
REQ-004 Parameter ACK_TIMEOUT, 8'd255, maximum wait for irq_ack in cycles.
REQ-005 Port list, one per line:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- int_reg  in  32  interrupt control CSR image
- ext_irq_high  in  1  asynchronous external high-priority request line
- irq_ack  in  1  core accepted the vector (single-cycle pulse)
- Iret  in  1  core executed return-from-interrupt (single-cycle pulse)
- irq_req  out  1  request to core
- irq_vector  out  32  target PC, valid while irq_req=1
- interrupt_pin_high  out  1  one-cycle pulse to CSR on high-level entry
- interrupt_pin_low  out  1  one-cycle pulse to CSR on low-level entry
- irq_level  out  2  00 none, 01 low, 10 high, 11 high nested over low
- irq_timeout  out  1  one-cycle pulse when ACK_TIMEOUT expires

Function
REQ-006 ext_irq_high SHALL pass through a 2-flop synchronizer, and a rising edge of the synchronized signal SHALL set the hi_pend latch.
REQ-007 Low sources SHALL be decoded as (enable, flag) pairs in int_reg: timer [15],[14]; SPI [11],[10]; UART [9],[8]; I2C [7],[6].
REQ-008 Low pending SHALL equal int_reg[0] (global enable) AND the OR of all (enable & flag) pairs; the priority order is timer > SPI > UART > I2C.
REQ-009 The low vector SHALL be VEC_LOW_BASE + 0x10*idx, where idx is timer=0, SPI=1, UART=2, I2C=3, computed in 32-bit arithmetic.
REQ-010 The FSM states SHALL be IDLE, REQ_HIGH, REQ_LOW, SERV_LOW, SERV_HIGH, REQ_NEST, SERV_NEST.
REQ-011 In IDLE, the FSM SHALL go to REQ_HIGH if hi_pend is set, else to REQ_LOW if low pending is set (latching idx), else stay in IDLE; the decision takes 1 cycle.
REQ-012 In every REQ_* state, irq_req SHALL be 1 and irq_vector SHALL hold stable (VEC_HIGH, or the latched low vector).
REQ-013 irq_ack in REQ_HIGH SHALL move the FSM to SERV_HIGH, clear hi_pend, and pulse interrupt_pin_high in the same cycle.
REQ-014 irq_ack in REQ_LOW SHALL move the FSM to SERV_LOW and pulse interrupt_pin_low.
REQ-015 irq_ack in REQ_NEST SHALL move the FSM to SERV_NEST, clear hi_pend, and pulse interrupt_pin_high.
REQ-016 In SERV_LOW, hi_pend SHALL move the FSM to REQ_NEST (preemption); low sources SHALL never preempt any serviced level.
REQ-017 Iret in SERV_HIGH or SERV_LOW SHALL move the FSM to IDLE; Iret in SERV_NEST SHALL move the FSM to SERV_LOW.
REQ-018 Iret in IDLE or any REQ_* state SHALL be ignored.
REQ-019 If Iret and hi_pend coincide in SERV_LOW, Iret SHALL win (go to IDLE), hi_pend SHALL stay set, and REQ_HIGH SHALL follow on the next cycle.
REQ-020 A new high edge during SERV_HIGH or SERV_NEST SHALL set hi_pend, which is serviced only after the return; further edges while hi_pend is set SHALL be merged.
REQ-021 An 8-bit wait counter SHALL clear on entry to any REQ_* state and increment each cycle without irq_ack.
REQ-022 When the counter reaches ACK_TIMEOUT, irq_timeout SHALL pulse, irq_req SHALL drop, and the FSM SHALL return to IDLE (from REQ_HIGH/REQ_LOW) or SERV_LOW (from REQ_NEST), with hi_pend and the flags retained.
REQ-023 After a timeout, re-request SHALL occur no earlier than 1 cycle later.
REQ-024 If irq_ack and the timeout fall in the same cycle, irq_ack SHALL win.
REQ-025 irq_ack outside the REQ_* states SHALL be ignored.
REQ-026 irq_level SHALL be 01 in SERV_LOW/REQ_NEST, 10 in SERV_HIGH, 11 in SERV_NEST, and 00 otherwise; it is registered.
REQ-027 A clear of int_reg[0] or of a flag while in REQ_LOW SHALL not withdraw the request; the request completes or times out.

Reset
REQ-028 On rst=1, asynchronously, the state SHALL become IDLE and the synchronizer flops, hi_pend, idx and the wait counter SHALL clear.
REQ-029 On rst=1, all outputs SHALL be 0 (irq_vector=32'h0).
REQ-030 Reset asserted mid-request or mid-service SHALL abandon it without any pin pulse.
REQ-031 Operation SHALL resume on the first clk edge after rst falls.

Verification
REQ-032 Scenario: int_reg=32'h0000_C001 (timer) with irq_ack 3 cycles after irq_req -> irq_vector=32'h80, one interrupt_pin_low pulse, irq_level=01, then Iret -> 00.
REQ-033 Scenario: int_reg=32'h0000_0F01 (SPI+UART) -> vector 32'h90 (SPI) is taken first; the UART request at 32'hA0 follows after Iret when its flag is still set.
REQ-034 Scenario: an ext_irq_high edge during SERV_LOW -> REQ_NEST with vector 32'h40, ack pulses interrupt_pin_high and irq_level=11, first Iret gives 01, second Iret gives 00.
REQ-035 Scenario: Iret and a synchronized high edge in the same cycle in SERV_LOW -> IDLE for 1 cycle, then irq_req with vector 32'h40.
REQ-036 Scenario: no irq_ack for 255 cycles -> irq_timeout pulses once, irq_req=0, and re-request occurs with the same vector.
REQ-037 Scenario: rst asserted while in REQ_HIGH -> outputs 0 immediately, no pin pulse, and a pre-reset edge is not serviced.

Source files
------------

// File: rtl/int_ctrl.sv
// ----------------------------------------------------------------------------
// int_ctrl -- two-level interrupt controller with one level of nesting.
//
// A single external high-priority line is synchronised and edge-detected into
// a pending latch. Four low-priority sources are decoded from an interrupt
// CSR image as (enable, flag) pairs and gated by a global enable. A small FSM
// requests the core, waits for an acknowledge (bounded by a timeout), tracks
// the serviced level and lets the high source preempt a low service once.
//
// Ports
//   clk                 system clock
//   rst                 asynchronous active-high reset
//   int_reg[31:0]       interrupt control CSR image
//   ext_irq_high        asynchronous external high-priority request line
//   irq_ack             core accepted the vector (single-cycle pulse)
//   Iret                core executed return-from-interrupt (single-cycle pulse)
//   irq_req             request to core
//   irq_vector[31:0]    target PC, valid while irq_req=1, otherwise 0
//   interrupt_pin_high  one-cycle pulse when a high-level entry is accepted
//   interrupt_pin_low   one-cycle pulse when a low-level entry is accepted
//   irq_level[1:0]      00 none, 01 low, 10 high, 11 high nested over low
//   irq_timeout         one-cycle pulse when a request expires unacknowledged
// ----------------------------------------------------------------------------
module int_ctrl #(
    parameter logic [31:0] VEC_HIGH     = 32'h0000_0040,
    parameter logic [31:0] VEC_LOW_BASE = 32'h0000_0080,
    parameter logic [7:0]  ACK_TIMEOUT  = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] int_reg,
    input  logic        ext_irq_high,
    input  logic        irq_ack,
    input  logic        Iret,
    output logic        irq_req,
    output logic [31:0] irq_vector,
    output logic        interrupt_pin_high,
    output logic        interrupt_pin_low,
    output logic [1:0]  irq_level,
    output logic        irq_timeout
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REQ_HIGH  = 3'd1,
        REQ_LOW   = 3'd2,
        SERV_LOW  = 3'd3,
        SERV_HIGH = 3'd4,
        REQ_NEST  = 3'd5,
        SERV_NEST = 3'd6
    } state_t;

    localparam int NUM_LOW = 4;
    // Source index 0..3 = timer, SPI, UART, I2C (index order is priority order)
    localparam int EN_BIT   [NUM_LOW] = '{15, 11, 9, 7};
    localparam int FLAG_BIT [NUM_LOW] = '{14, 10, 8, 6};

    state_t      state_reg, state_next;
    logic        sync1_reg, sync2_reg, sync3_reg;
    logic        hi_pend_reg, hi_pend_next;
    logic [1:0]  idx_reg, idx_next;
    logic [7:0]  wait_cnt_reg, wait_cnt_next;
    logic [1:0]  level_reg, level_next;

    logic [NUM_LOW-1:0] src_active;
    logic        low_pend;
    logic [1:0]  low_idx;
    logic [31:0] low_vec;
    logic        hi_edge;
    logic        hi_clr;
    logic        is_req;
    logic        timeout_hit;

    logic        req_c;
    logic [31:0] vector_c;
    logic        pin_high_c;
    logic        pin_low_c;
    logic        timeout_c;

    // Bits of the CSR image this block does not decode.
    logic unused_int_reg;
    assign unused_int_reg = ^{int_reg[31:16], int_reg[13:12], int_reg[5:1]};

    // ------------------------------------------------------------------
    // Low-priority source decode
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_LOW; gi++) begin : g_low_src
            assign src_active[gi] = int_reg[EN_BIT[gi]] & int_reg[FLAG_BIT[gi]];
        end
    endgenerate

    assign low_pend = int_reg[0] & (|src_active);

    // Fixed priority: lowest index wins.
    always_comb begin
        low_idx = 2'd0;
        for (int i = NUM_LOW - 1; i >= 0; i--) begin
            if (src_active[i]) begin
                low_idx = i[1:0];
            end
        end
    end

    // Vector is built from the latched index so it stays stable for the
    // whole request even if the CSR image changes underneath it.
    assign low_vec = VEC_LOW_BASE + {26'd0, idx_reg, 4'h0};

    // ------------------------------------------------------------------
    // External high line: 2-flop synchroniser plus an edge-detect flop
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            sync3_reg <= 1'b0;
        end else begin
            sync1_reg <= ext_irq_high;
            sync2_reg <= sync1_reg;
            sync3_reg <= sync2_reg;
        end
    end

    assign hi_edge = sync2_reg & ~sync3_reg;

    // A fresh edge in the same cycle as an acknowledge-clear is kept so a
    // second request is never lost; edges while already pending merge.
    assign hi_pend_next = hi_edge | (hi_pend_reg & ~hi_clr);

    // ------------------------------------------------------------------
    // Acknowledge wait counter
    // ------------------------------------------------------------------
    assign is_req = (state_reg == REQ_HIGH) || (state_reg == REQ_LOW) ||
                    (state_reg == REQ_NEST);

    // An acknowledge in the expiry cycle takes precedence over the timeout.
    assign timeout_hit = is_req && !irq_ack && (wait_cnt_reg == ACK_TIMEOUT);

    // Counter is held at zero outside REQ_* states, so it starts from zero
    // on every REQ_* entry.
    assign wait_cnt_next = (is_req && !irq_ack && !timeout_hit) ?
                           (wait_cnt_reg + 8'd1) : 8'd0;

    // ------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        hi_clr     = 1'b0;
        req_c      = 1'b0;
        vector_c   = 32'h0;
        pin_high_c = 1'b0;
        pin_low_c  = 1'b0;
        timeout_c  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (hi_pend_reg) begin
                    state_next = REQ_HIGH;
                end else if (low_pend) begin
                    state_next = REQ_LOW;
                    idx_next   = low_idx;
                end
            end

            REQ_HIGH: begin
                req_c    = 1'b1;
                vector_c = VEC_HIGH;
                if (irq_ack) begin
                    state_next = SERV_HIGH;
                    hi_clr     = 1'b1;
                    pin_high_c = 1'b1;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                    timeout_c  = 1'b1;
                end
            end

            // Once requested, a low entry is not withdrawn by CSR changes.
            REQ_LOW: begin
                req_c    = 1'b1;
                vector_c = low_vec;
                if (irq_ack) begin
                    state_next = SERV_LOW;
                    pin_low_c  = 1'b1;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                    timeout_c  = 1'b1;
                end
            end

            REQ_NEST: begin
                req_c    = 1'b1;
                vector_c = VEC_HIGH;
                if (irq_ack) begin
                    state_next = SERV_NEST;
                    hi_clr     = 1'b1;
                    pin_high_c = 1'b1;
                end else if (timeout_hit) begin
                    // Fall back to the low service that was interrupted.
                    state_next = SERV_LOW;
                    timeout_c  = 1'b1;
                end
            end

            // Return wins over a coinciding high request; the pending high
            // request is then taken from IDLE on the following cycle.
            SERV_LOW: begin
                if (Iret) begin
                    state_next = IDLE;
                end else if (hi_pend_reg) begin
                    state_next = REQ_NEST;
                end
            end

            SERV_HIGH: begin
                if (Iret) begin
                    state_next = IDLE;
                end
            end

            SERV_NEST: begin
                if (Iret) begin
                    state_next = SERV_LOW;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        level_next = 2'b00;
        case (state_next)
            SERV_LOW,
            REQ_NEST:  level_next = 2'b01;
            SERV_HIGH: level_next = 2'b10;
            SERV_NEST: level_next = 2'b11;
            default:   level_next = 2'b00;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            hi_pend_reg  <= 1'b0;
            idx_reg      <= 2'd0;
            wait_cnt_reg <= 8'd0;
            level_reg    <= 2'b00;
        end else begin
            state_reg    <= state_next;
            hi_pend_reg  <= hi_pend_next;
            idx_reg      <= idx_next;
            wait_cnt_reg <= wait_cnt_next;
            level_reg    <= level_next;
        end
    end

    // Outputs decode from the registered state, so reset forces them to
    // zero immediately.
    assign irq_req            = req_c;
    assign irq_vector         = vector_c;
    assign interrupt_pin_high = pin_high_c;
    assign interrupt_pin_low  = pin_low_c;
    assign irq_timeout        = timeout_c;
    assign irq_level          = level_reg;

endmodule

// File: tb/tb_int_ctrl.sv
// ----------------------------------------------------------------------------
// Testbench for int_ctrl: directed scenarios with hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_int_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] int_reg;
    logic        ext_irq_high;
    logic        irq_ack;
    logic        Iret;
    logic        irq_req;
    logic [31:0] irq_vector;
    logic        interrupt_pin_high;
    logic        interrupt_pin_low;
    logic [1:0]  irq_level;
    logic        irq_timeout;

    int n_cmp;
    int n_bad;

    int_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .int_reg            (int_reg),
        .ext_irq_high       (ext_irq_high),
        .irq_ack            (irq_ack),
        .Iret               (Iret),
        .irq_req            (irq_req),
        .irq_vector         (irq_vector),
        .interrupt_pin_high (interrupt_pin_high),
        .interrupt_pin_low  (interrupt_pin_low),
        .irq_level          (irq_level),
        .irq_timeout        (irq_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive a timer request through to SERV_LOW with the CSR cleared.
    task automatic go_serv_low;
        int_reg = 32'h0000_C001;
        tick();
        irq_ack = 1'b1;
        int_reg = 32'h0;
        tick();
        irq_ack = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; int_reg = 32'h0; ext_irq_high = 1'b0; irq_ack = 1'b0; Iret = 1'b0;
        #2;
        n_cmp++; if (irq_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %0b want 0", irq_req); end
        n_cmp++; if (irq_vector !== 32'h0) begin n_bad++; $display("FAIL reset_vec: got %08h want 00000000", irq_vector); end
        n_cmp++; if (irq_level !== 2'b00) begin n_bad++; $display("FAIL reset_level: got %02b want 00", irq_level); end
        n_cmp++; if ({interrupt_pin_high, interrupt_pin_low, irq_timeout} !== 3'b000) begin
            n_bad++; $display("FAIL reset_pulses: got %03b want 000", {interrupt_pin_high, interrupt_pin_low, irq_timeout});
        end
        tick(); tick();
        rst = 1'b0;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_ignored;
        irq_ack = 1'b1; Iret = 1'b1;
        #1;
        n_cmp++; if ({interrupt_pin_high, interrupt_pin_low} !== 2'b00) begin
            n_bad++; $display("FAIL idle_ack_pins: got %02b want 00", {interrupt_pin_high, interrupt_pin_low});
        end
        tick();
        irq_ack = 1'b0; Iret = 1'b0;
        #1;
        n_cmp++; if ({irq_req, irq_level} !== 3'b000) begin
            n_bad++; $display("FAIL idle_ignore: got req/level %03b want 000", {irq_req, irq_level});
        end
        $display("test_ignored done");
    endtask

    task automatic test_timer;
        int_reg = 32'h0000_C001;
        tick();
        n_cmp++; if (irq_req !== 1'b1) begin n_bad++; $display("FAIL timer_req: got %0b want 1", irq_req); end
        n_cmp++; if (irq_vector !== 32'h80) begin n_bad++; $display("FAIL timer_vec: got %08h want 00000080", irq_vector); end
        // Clearing the CSR must not withdraw the request.
        int_reg = 32'h0;
        tick(); tick(); tick();
        n_cmp++; if ({irq_req, irq_vector} !== {1'b1, 32'h80}) begin
            n_bad++; $display("FAIL timer_hold: got req %0b vec %08h want 1 00000080", irq_req, irq_vector);
        end
        irq_ack = 1'b1;
        #1;
        n_cmp++; if ({interrupt_pin_low, interrupt_pin_high} !== 2'b10) begin
            n_bad++; $display("FAIL timer_pin: got low/high %02b want 10", {interrupt_pin_low, interrupt_pin_high});
        end
        tick();
        irq_ack = 1'b0;
        #1;
        n_cmp++; if ({irq_level, irq_req, interrupt_pin_low} !== 4'b0100) begin
            n_bad++; $display("FAIL timer_serv: got level/req/pin %04b want 0100", {irq_level, irq_req, interrupt_pin_low});
        end
        Iret = 1'b1;
        tick();
        Iret = 1'b0;
        tick();
        n_cmp++; if ({irq_level, irq_req} !== 3'b000) begin
            n_bad++; $display("FAIL timer_iret: got level/req %03b want 000", {irq_level, irq_req});
        end
        $display("test_timer done");
    endtask

    task automatic test_priority;
        int_reg = 32'h0000_0F01;
        tick();
        n_cmp++; if ({irq_req, irq_vector} !== {1'b1, 32'h90}) begin
            n_bad++; $display("FAIL prio_spi: got req %0b vec %08h want 1 00000090", irq_req, irq_vector);
        end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        int_reg = 32'h0000_0B01;   // SPI flag cleared by its handler
        Iret = 1'b1;
        tick();
        Iret = 1'b0;
        #1;
        n_cmp++; if (irq_req !== 1'b0) begin n_bad++; $display("FAIL prio_idle: got %0b want 0", irq_req); end
        tick();
        n_cmp++; if ({irq_req, irq_vector} !== {1'b1, 32'hA0}) begin
            n_bad++; $display("FAIL prio_uart: got req %0b vec %08h want 1 000000a0", irq_req, irq_vector);
        end
        irq_ack = 1'b1;
        int_reg = 32'h0;
        tick();
        irq_ack = 1'b0;
        Iret = 1'b1;
        tick();
        Iret = 1'b0;
        #1;
        n_cmp++; if (irq_level !== 2'b00) begin n_bad++; $display("FAIL prio_end: got %02b want 00", irq_level); end
        $display("test_priority done");
    endtask

    task automatic test_nest;
        go_serv_low();
        n_cmp++; if (irq_level !== 2'b01) begin n_bad++; $display("FAIL nest_low: got %02b want 01", irq_level); end
        ext_irq_high = 1'b1;
        tick(); tick(); tick();
        n_cmp++; if (irq_req !== 1'b0) begin n_bad++; $display("FAIL nest_early: got %0b want 0", irq_req); end
        ext_irq_high = 1'b0;
        tick();
        n_cmp++; if ({irq_req, irq_vector, irq_level} !== {1'b1, 32'h40, 2'b01}) begin
            n_bad++; $display("FAIL nest_req: got req %0b vec %08h lvl %02b want 1 00000040 01", irq_req, irq_vector, irq_level);
        end
        irq_ack = 1'b1;
        #1;
        n_cmp++; if ({interrupt_pin_high, interrupt_pin_low} !== 2'b10) begin
            n_bad++; $display("FAIL nest_pin: got high/low %02b want 10", {interrupt_pin_high, interrupt_pin_low});
        end
        tick();
        irq_ack = 1'b0;
        #1;
        n_cmp++; if ({irq_level, irq_req} !== 3'b110) begin
            n_bad++; $display("FAIL nest_serv: got level/req %03b want 110", {irq_level, irq_req});
        end
        Iret = 1'b1;
        tick();
        Iret = 1'b0;
        tick();
        n_cmp++; if ({irq_level, irq_req} !== 3'b010) begin
            n_bad++; $display("FAIL nest_iret1: got level/req %03b want 010", {irq_level, irq_req});
        end
        Iret = 1'b1;
        tick();
        Iret = 1'b0;
        #1;
        n_cmp++; if ({irq_level, irq_req} !== 3'b000) begin
            n_bad++; $display("FAIL nest_iret2: got level/req %03b want 000", {irq_level, irq_req});
        end
        $display("test_nest done");
    endtask

    task automatic test_iret_collide;
        go_serv_low();
        ext_irq_high = 1'b1;
        tick(); tick(); tick();   // high pending now set, still in SERV_LOW
        ext_irq_high = 1'b0;
        Iret = 1'b1;
        tick();
        Iret = 1'b0;
        #1;
        n_cmp++; if ({irq_req, irq_level} !== 3'b000) begin
            n_bad++; $display("FAIL coll_idle: got req/level %03b want 000", {irq_req, irq_level});
        end
        tick();
        n_cmp++; if ({irq_req, irq_vector, irq_level} !== {1'b1, 32'h40, 2'b00}) begin
            n_bad++; $display("FAIL coll_req: got req %0b vec %08h lvl %02b want 1 00000040 00", irq_req, irq_vector, irq_level);
        end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        #1;
        n_cmp++; if (irq_level !== 2'b10) begin n_bad++; $display("FAIL coll_serv: got %02b want 10", irq_level); end
        Iret = 1'b1;
        tick();
        Iret = 1'b0;
        #1;
        n_cmp++; if ({irq_req, irq_level} !== 3'b000) begin
            n_bad++; $display("FAIL coll_end: got req/level %03b want 000", {irq_req, irq_level});
        end
        $display("test_iret_collide done");
    endtask

    task automatic test_timeout;
        int pulses;
        pulses = 0;
        int_reg = 32'h0000_C001;
        tick();
        for (int k = 0; k < 255; k++) begin
            if (irq_timeout === 1'b1) pulses++;
            tick();
        end
        n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL to_early: got %0d pulses want 0", pulses); end
        n_cmp++; if ({irq_timeout, irq_req} !== 2'b11) begin
            n_bad++; $display("FAIL to_pulse: got timeout/req %02b want 11", {irq_timeout, irq_req});
        end
        tick();
        n_cmp++; if ({irq_timeout, irq_req} !== 2'b00) begin
            n_bad++; $display("FAIL to_drop: got timeout/req %02b want 00", {irq_timeout, irq_req});
        end
        tick();
        n_cmp++; if ({irq_req, irq_vector} !== {1'b1, 32'h80}) begin
            n_bad++; $display("FAIL to_rereq: got req %0b vec %08h want 1 00000080", irq_req, irq_vector);
        end
        // Acknowledge arriving exactly in the expiry cycle wins.
        for (int k = 0; k < 255; k++) tick();
        irq_ack = 1'b1;
        #1;
        n_cmp++; if ({irq_timeout, interrupt_pin_low} !== 2'b01) begin
            n_bad++; $display("FAIL to_ackwin: got timeout/pin %02b want 01", {irq_timeout, interrupt_pin_low});
        end
        tick();
        irq_ack = 1'b0;
        int_reg = 32'h0;
        #1;
        n_cmp++; if (irq_level !== 2'b01) begin n_bad++; $display("FAIL to_serv: got %02b want 01", irq_level); end
        Iret = 1'b1;
        tick();
        Iret = 1'b0;
        #1;
        $display("test_timeout done");
    endtask

    task automatic test_reset_mid;
        int bad_req;
        bad_req = 0;
        int_reg = 32'h0;
        ext_irq_high = 1'b1;
        tick(); tick();
        ext_irq_high = 1'b0;
        for (int i = 0; i < 8 && irq_req !== 1'b1; i++) tick();
        n_cmp++; if ({irq_req, irq_vector} !== {1'b1, 32'h40}) begin
            n_bad++; $display("FAIL rstm_req: got req %0b vec %08h want 1 00000040", irq_req, irq_vector);
        end
        ext_irq_high = 1'b1;       // another edge entering the synchroniser
        tick();
        irq_ack = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if ({irq_req, irq_vector, interrupt_pin_high, irq_level} !== 36'h0) begin
            n_bad++; $display("FAIL rstm_out: got req %0b vec %08h pin %0b lvl %02b want all 0",
                              irq_req, irq_vector, interrupt_pin_high, irq_level);
        end
        ext_irq_high = 1'b0;
        irq_ack = 1'b0;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (irq_req !== 1'b0 || interrupt_pin_high !== 1'b0) bad_req++;
        end
        n_cmp++; if (bad_req != 0) begin n_bad++; $display("FAIL rstm_after: got %0d active cycles want 0", bad_req); end
        $display("test_reset_mid done");
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_ignored();
        test_timer();
        test_priority();
        test_nest();
        test_iret_collide();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
